// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Requester side of the instruction memory read port. Holds the PC, drives
//   the memory address, captures the same-cycle read data into a small
//   prefetch FIFO and presents {pc, instr} to decode over valid/ready.
//   A redirect from execute flushes the FIFO and reloads the PC.
// Ports
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_fetch_en           1 = fetch allowed, 0 = hold PC and let the FIFO drain
//   o_imem_addr          byte address to instruction memory (the PC register)
//   i_imem_rdata         instruction at o_imem_addr, valid the same cycle
//   o_if_valid/i_if_ready/o_if_instr/o_if_pc   decode handshake + FIFO head
//   i_redirect_valid     flush and load i_redirect_target (bits [1:0] ignored)
//   o_fifo_count         current FIFO occupancy
module instruction_fetch_unit #(
  parameter int                  ADDR_WIDTH   = 32,
  parameter int                  DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  FIFO_DEPTH   = 2,
  localparam int                 PW           = $clog2(FIFO_DEPTH),
  localparam int                 CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fetch_en,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_if_valid,
  input  logic                  i_if_ready,
  output logic [DATA_WIDTH-1:0] o_if_instr,
  output logic [ADDR_WIDTH-1:0] o_if_pc,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_target,
  output logic [CW-1:0]         o_fifo_count
);

  // Operating state is fully derived from count/inputs; nothing extra is stored.
  typedef enum logic [3:0] {
    S_FETCH = 4'b0001,
    S_STALL = 4'b0010,
    S_IDLE  = 4'b0100,
    S_FLUSH = 4'b1000
  } state_e;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];

  state_e w_state;
  logic   w_empty;
  logic   w_full;
  logic   w_pop;
  logic   w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));

  // Valid is qualified by redirect so decode never consumes a doomed entry.
  assign o_if_valid = ~w_empty & ~i_redirect_valid;
  assign w_pop      = o_if_valid & i_if_ready;

  always_comb begin
    w_state = S_FETCH;
    if (i_redirect_valid)           w_state = S_FLUSH;
    else if (!i_fetch_en)           w_state = S_IDLE;
    else if (w_full && !w_pop)      w_state = S_STALL;
  end

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign w_push = (w_state == S_FETCH);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc     <= RESET_VECTOR;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (i_redirect_valid) begin
      r_pc     <= {i_redirect_target[ADDR_WIDTH-1:2], 2'b00};
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + ADDR_WIDTH'(4);
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_pc;
      r_instr_mem[r_wr_ptr] <= i_imem_rdata;
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_fifo_count = r_count;
  assign o_if_instr   = w_empty ? '0 : r_instr_mem[r_rd_ptr];
  assign o_if_pc      = w_empty ? '0 : r_pc_mem[r_rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic [31:0] a_addr, a_rdata, a_instr, a_pc;
  logic        a_valid;
  logic [1:0]  a_count;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc;
  logic        b_valid;
  logic [1:0]  b_count;

  int vectors   = 0;
  int miscomp   = 0;

  always #5 clk = ~clk;

  // Memory: 0x11/0x22/0x33 at 0/4/8, elsewhere 0xC0000000 | addr.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0:   mem_f = 32'h11;
      32'h4:   mem_f = 32'h22;
      32'h8:   mem_f = 32'h33;
      default: mem_f = 32'hC000_0000 | a;
    endcase
  endfunction

  assign a_rdata = mem_f(a_addr);
  assign b_rdata = mem_f(b_addr);

  instruction_fetch_unit u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_en(fetch_en),
    .o_imem_addr(a_addr), .i_imem_rdata(a_rdata),
    .o_if_valid(a_valid), .i_if_ready(if_ready),
    .o_if_instr(a_instr), .o_if_pc(a_pc),
    .i_redirect_valid(redirect_valid), .i_redirect_target(redirect_target),
    .o_fifo_count(a_count)
  );

  instruction_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_en(fetch_en),
    .o_imem_addr(b_addr), .i_imem_rdata(b_rdata),
    .o_if_valid(b_valid), .i_if_ready(if_ready),
    .o_if_instr(b_instr), .o_if_pc(b_pc),
    .i_redirect_valid(redirect_valid), .i_redirect_target(redirect_target),
    .o_fifo_count(b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscomp++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    tick(); tick();

    // reset state
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_pc",    a_pc,    32'h0);
    chk("rst_addr",  a_addr,  32'h0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_addr_wrap", b_addr, 32'hFFFF_FFFC);

    // streaming, plus wrap-around instance
    rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    tick();
    chk("s1_valid", 32'(a_valid), 32'd1);
    chk("s1_pc",    a_pc,    32'h0);
    chk("s1_instr", a_instr, 32'h11);
    chk("w1_pc",    b_pc,    32'hFFFF_FFFC);
    tick();
    chk("s2_pc",    a_pc,    32'h4);
    chk("s2_instr", a_instr, 32'h22);
    chk("w2_pc",    b_pc,    32'h0);
    chk("w2_instr", b_instr, 32'h11);
    tick();
    chk("s3_pc",    a_pc,    32'h8);
    chk("s3_instr", a_instr, 32'h33);
    chk("s3_count", 32'(a_count), 32'd1);
    chk("w3_pc",    b_pc,    32'h4);

    // backpressure fills the FIFO, then drains without gaps or repeats
    rst_n = 1'b0; tick();
    rst_n = 1'b1; if_ready = 1'b0;
    repeat (5) tick();
    chk("bp_count", 32'(a_count), 32'd2);
    chk("bp_addr",  a_addr, 32'h8);
    chk("bp_pc0",   a_pc,   32'h0);
    if_ready = 1'b1;
    tick();
    chk("bp_pc4",   a_pc,   32'h4);
    tick();
    chk("bp_pc8",   a_pc,   32'h8);
    tick();
    chk("bp_pcC",   a_pc,   32'hC);
    chk("bp_instrC", a_instr, 32'hC000_000C);

    // redirect while full
    if_ready = 1'b0;
    tick(); tick();
    chk("rd_full", 32'(a_count), 32'd2);
    redirect_valid = 1'b1; redirect_target = 32'h40;
    #1;
    chk("rd_valid_q", 32'(a_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_count", 32'(a_count), 32'd0);
    chk("rd_addr",  a_addr, 32'h40);
    tick();
    chk("rd_valid", 32'(a_valid), 32'd1);
    chk("rd_pc",    a_pc,    32'h40);
    chk("rd_instr", a_instr, 32'hC000_0040);

    // misaligned target is truncated
    if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h43;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("mis_addr", a_addr, 32'h40);
    tick();
    chk("mis_pc",   a_pc,   32'h40);

    // back-to-back redirects: last wins
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("b2b_addr", a_addr, 32'h200);
    tick();
    chk("b2b_pc",   a_pc,   32'h200);

    // fetch disabled: PC holds, FIFO drains
    fetch_en = 1'b0;
    tick();
    chk("idle_count", 32'(a_count), 32'd0);
    chk("idle_valid", 32'(a_valid), 32'd0);
    chk("idle_addr",  a_addr, 32'h204);
    tick();
    chk("idle_addr2", a_addr, 32'h204);

    // reset overrides a full FIFO with decode ready
    fetch_en = 1'b1; if_ready = 1'b0;
    tick(); tick();
    chk("r6_full", 32'(a_count), 32'd2);
    if_ready = 1'b1; rst_n = 1'b0;
    tick();
    chk("r6_valid", 32'(a_valid), 32'd0);
    chk("r6_count", 32'(a_count), 32'd0);
    chk("r6_addr",  a_addr, 32'h0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

endmodule
